// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 write-data path.
// Holds the write-data FSM state encoding and the legal-burst-length check.
package mpmc10_pkg;

    typedef enum logic [1:0] {
        WDF_IDLE = 2'd0,
        WDF_DATA = 2'd1,
        WDF_DONE = 2'd2
    } wdf_state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Only 4:1 (one beat) and 2:1 (two beats) MIG modes exist.
    function automatic bit nbeats_legal(input int unsigned n);
        return (n == 1) || (n == 2);
    endfunction

endpackage

// File: rtl/mpmc10_wdf_beat_sel.sv
// Registered beat slice-select: picks one DW-wide beat and its byte enables
// from a packed buffer and converts the enables to a MIG mask.
module mpmc10_wdf_beat_sel #(
    parameter int DW       = 128,
    parameter int NB_TOTAL = 4,
    parameter int IW       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [NB_TOTAL*DW-1:0]     src_data,
    input  logic [NB_TOTAL*DW/8-1:0]   src_sel,
    input  logic [IW-1:0]              idx,
    output logic [DW-1:0]              data,
    output logic [DW/8-1:0]            mask
);

    localparam int MW = DW / 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            mask <= '1;
        end else if (load) begin
            data <= src_data[idx*DW +: DW];
            mask <= ~src_sel[idx*MW +: MW];
        end
    end

endmodule

// File: rtl/mpmc10_wdf_burst_gen.sv
// Write-data sequencer: latches one multi-strip request and streams it beat by
// beat into the MIG write-data FIFO under app_wdf_rdy back-pressure.
module mpmc10_wdf_burst_gen
    import mpmc10_pkg::*;
#(
    parameter int DW         = 128,
    parameter int NBEATS     = 1,
    parameter int MAX_STRIPS = 4,
    parameter int SW         = $clog2(MAX_STRIPS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [SW-1:0]                     req_strips,
    input  logic [MAX_STRIPS*NBEATS*DW-1:0]   req_data,
    input  logic [MAX_STRIPS*NBEATS*DW/8-1:0] req_sel,
    input  logic                              app_wdf_rdy,
    output logic                              app_wdf_wren,
    output logic                              app_wdf_end,
    output logic [DW-1:0]                     app_wdf_data,
    output logic [DW/8-1:0]                   app_wdf_mask,
    output logic                              busy,
    output logic                              done
);

    localparam int NBT = MAX_STRIPS * NBEATS;
    localparam int IW  = (NBT > 1) ? $clog2(NBT) : 1;

    if (!nbeats_legal(NBEATS)) begin : g_nbeats_check
        $error("mpmc10_wdf_burst_gen: NBEATS must be 1 or 2");
    end

    wdf_state_t           state, state_n;
    logic [SW-1:0]        strip_cnt, strip_n, strips_q, strips_eff;
    logic [0:0]           beat_cnt, beat_n;
    logic [NBT*DW-1:0]    buf_data, src_data;
    logic [NBT*DW/8-1:0]  buf_sel, src_sel;
    logic                 accept, load, last_beat, last_strip;
    logic [IW-1:0]        idx_n;
    logic                 wren_q, end_q, done_q;

    assign accept     = req_valid && (state == WDF_IDLE);
    assign strips_eff = (req_strips > SW'(MAX_STRIPS)) ? SW'(MAX_STRIPS) : req_strips;
    assign last_beat  = (beat_cnt == 1'(NBEATS - 1));
    assign last_strip = (strip_cnt == strips_q - SW'(1));

    always_comb begin
        state_n = state;
        strip_n = strip_cnt;
        beat_n  = beat_cnt;
        load    = FALSE;
        case (state)
            WDF_IDLE: begin
                if (req_valid) begin
                    strip_n = '0;
                    beat_n  = '0;
                    if (req_strips == '0) begin
                        state_n = WDF_DONE;
                    end else begin
                        state_n = WDF_DATA;
                        load    = TRUE;
                    end
                end
            end
            WDF_DATA: begin
                if (app_wdf_rdy) begin
                    if (last_beat) begin
                        beat_n  = '0;
                        strip_n = strip_cnt + SW'(1);
                        if (last_strip) state_n = WDF_DONE;
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                    load = (state_n == WDF_DATA);
                end
            end
            WDF_DONE: state_n = WDF_IDLE;
            default:  state_n = WDF_IDLE;
        endcase
    end

    // The first beat is selected straight from the request inputs, since the
    // buffer is being written on that same edge.
    assign src_data = accept ? req_data : buf_data;
    assign src_sel  = accept ? req_sel  : buf_sel;
    assign idx_n    = IW'(strip_n) * IW'(NBEATS) + IW'(beat_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WDF_IDLE;
            strip_cnt <= '0;
            beat_cnt  <= '0;
            strips_q  <= '0;
            buf_data  <= '0;
            buf_sel   <= '0;
            wren_q    <= 1'b0;
            end_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            strip_cnt <= strip_n;
            beat_cnt  <= beat_n;
            if (accept) begin
                strips_q <= strips_eff;
                buf_data <= req_data;
                buf_sel  <= req_sel;
            end
            wren_q <= (state_n == WDF_DATA);
            end_q  <= (state_n == WDF_DATA) && (beat_n == 1'(NBEATS - 1));
            done_q <= (state_n == WDF_DONE);
        end
    end

    mpmc10_wdf_beat_sel #(
        .DW       (DW),
        .NB_TOTAL (NBT),
        .IW       (IW)
    ) u_beat_sel (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .src_data (src_data),
        .src_sel  (src_sel),
        .idx      (idx_n),
        .data     (app_wdf_data),
        .mask     (app_wdf_mask)
    );

    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = end_q;
    assign done         = done_q;
    assign req_ready    = (state == WDF_IDLE);
    assign busy         = (state != WDF_IDLE);

endmodule

// File: tb/tb_mpmc10_wdf_burst_gen.sv
// Scoreboard bench: a 2:1-mode instance (a_*) and a 4:1-mode instance (b_*)
// share clock and reset; expected beats are queued at issue and popped on transfer.
module tb_mpmc10_wdf_burst_gen;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  m;
        logic        e;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;

    logic         a_valid, a_ready, a_rdy, a_wren, a_end, a_busy, a_done;
    logic [2:0]   a_strips;
    logic [255:0] a_data;
    logic [31:0]  a_sel;
    logic [31:0]  a_wdata;
    logic [3:0]   a_mask;

    logic         b_valid, b_ready, b_rdy, b_wren, b_end, b_busy, b_done;
    logic [2:0]   b_strips;
    logic [127:0] b_data;
    logic [15:0]  b_sel;
    logic [31:0]  b_wdata;
    logic [3:0]   b_mask;

    int    total = 0;
    int    bad   = 0;
    int    a_xfer = 0;
    beat_t qa[$];
    beat_t qb[$];
    beat_t ea, eb;

    always #5 clk = ~clk;

    mpmc10_wdf_burst_gen #(.DW(32), .NBEATS(2), .MAX_STRIPS(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_strips(a_strips),
        .req_data(a_data), .req_sel(a_sel),
        .app_wdf_rdy(a_rdy), .app_wdf_wren(a_wren), .app_wdf_end(a_end),
        .app_wdf_data(a_wdata), .app_wdf_mask(a_mask),
        .busy(a_busy), .done(a_done)
    );

    mpmc10_wdf_burst_gen #(.DW(32), .NBEATS(1), .MAX_STRIPS(4)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_strips(b_strips),
        .req_data(b_data), .req_sel(b_sel),
        .app_wdf_rdy(b_rdy), .app_wdf_wren(b_wren), .app_wdf_end(b_end),
        .app_wdf_data(b_wdata), .app_wdf_mask(b_mask),
        .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted beat must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_wren && a_rdy) begin
                a_xfer++;
                if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
                else begin
                    ea = qa.pop_front();
                    chk("a_beat_data", a_wdata, ea.d);
                    chk("a_beat_mask", a_mask, ea.m);
                    chk("a_beat_end", a_end, ea.e);
                end
            end
            if (b_wren && b_rdy) begin
                if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
                else begin
                    eb = qb.pop_front();
                    chk("b_beat_data", b_wdata, eb.d);
                    chk("b_beat_mask", b_mask, eb.m);
                    chk("b_beat_end", b_end, eb.e);
                end
            end
        end
    end

    task automatic issue(input bit b, input int strips, input logic [255:0] d, input logic [31:0] s);
        int    n;
        int    nb;
        beat_t e;
        n  = (strips > 4) ? 4 : strips;
        nb = b ? 1 : 2;
        @(negedge clk);
        for (int k = 0; k < n * nb; k++) begin
            e.d = d[k*32 +: 32];
            e.m = ~s[k*4 +: 4];
            e.e = (nb == 1) || (k % 2 == 1);
            if (b) qb.push_back(e);
            else   qa.push_back(e);
        end
        if (b) begin
            b_valid = 1'b1; b_strips = 3'(strips); b_data = d[127:0]; b_sel = s[15:0];
        end else begin
            a_valid = 1'b1; a_strips = 3'(strips); a_data = d; a_sel = s;
        end
        @(posedge clk);
        #1;
        // Scramble request inputs after acceptance; the buffer must hold.
        if (b) begin b_valid = 1'b0; b_data = ~b_data; b_sel = ~b_sel; b_strips = 3'd3; end
        else   begin a_valid = 1'b0; a_data = ~a_data; a_sel = ~a_sel; a_strips = 3'd3; end
    endtask

    task automatic run(input bit b, input int exp_wr, input string tag);
        int wr   = 0;
        int cyc  = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (b ? b_done : a_done) seen = 1;
            else if (b ? b_wren : a_wren) wr++;
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_wren_cycles"}, wr, exp_wr);
        chk({tag, "_done_latency"}, cyc, exp_wr + 1);
        @(negedge clk);
        chk({tag, "_ready_after"}, b ? b_ready : a_ready, 1);
        chk({tag, "_done_one_cycle"}, b ? b_done : a_done, 0);
    endtask

    logic [255:0] d;
    logic [31:0]  s;
    int           x0;

    initial begin
        rst = 1'b1;
        a_valid = 0; a_strips = 0; a_data = '0; a_sel = '0; a_rdy = 1;
        b_valid = 0; b_strips = 0; b_data = '0; b_sel = '0; b_rdy = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_wren", a_wren, 0);
        chk("rst_a_mask", a_mask, 4'hF);
        chk("rst_a_data", a_wdata, 0);
        chk("rst_b_done", b_done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 4:1 mode, single strip, all bytes enabled
        d = '0; d[31:0] = 32'hA5A5_0001; s = '1;
        issue(1, 1, d, s);
        @(negedge clk);
        chk("b1_wren", b_wren, 1);
        chk("b1_end", b_end, 1);
        chk("b1_mask", b_mask, 0);
        chk("b1_busy", b_busy, 1);
        chk("b1_ready", b_ready, 0);
        @(negedge clk);
        chk("b1_done", b_done, 1);
        chk("b1_wren_off", b_wren, 0);
        @(negedge clk);
        chk("b1_done_off", b_done, 0);
        chk("b1_ready_back", b_ready, 1);

        // 4:1 mode, four strips, mixed byte enables
        for (int k = 0; k < 8; k++) begin d[k*32 +: 32] = 32'hB000 + k; s[k*4 +: 4] = 4'(k * 5 + 2); end
        issue(1, 4, d, s);
        run(1, 4, "b4");

        // 2:1 mode, three strips, data 0..5
        for (int k = 0; k < 8; k++) begin d[k*32 +: 32] = 32'(k); s[k*4 +: 4] = 4'hF; end
        issue(0, 3, d, s);
        run(0, 6, "a3");

        // 2:1 mode, two strips, rdy low for 3 cycles while beat 2 is presented
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'h100 + k;
        s = 32'h0000_5A3F;
        x0 = a_xfer;
        issue(0, 2, d, s);
        @(posedge clk); @(posedge clk); #1 a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_wren", a_wren, 1);
            chk("bp_hold_data", a_wdata, 32'h102);
            chk("bp_hold_end", a_end, 0);
            chk("bp_hold_mask", a_mask, 4'h5);
            @(posedge clk);
        end
        #1 a_rdy = 1'b1;
        @(negedge clk);
        chk("bp_hold_data4", a_wdata, 32'h102);
        run(0, 1, "bp");
        chk("bp_xfer_count", a_xfer - x0, 4);

        // zero-strip request
        issue(0, 0, d, s);
        @(negedge clk);
        chk("z_wren", a_wren, 0);
        chk("z_done", a_done, 1);
        @(negedge clk);
        chk("z_ready", a_ready, 1);
        chk("z_done_off", a_done, 0);

        // over-range strip count clamps to MAX_STRIPS
        for (int k = 0; k < 8; k++) begin d[k*32 +: 32] = 32'hC000 + k; s[k*4 +: 4] = 4'(k * 3 + 1); end
        issue(0, 7, d, s);
        run(0, 8, "over");

        // reset after beat 0 is taken, while beat 1 is on the outputs
        for (int k = 0; k < 8; k++) begin d[k*32 +: 32] = 32'hD000 + k; s[k*4 +: 4] = 4'hF; end
        issue(0, 2, d, s);
        @(posedge clk); #2;
        chk("mr_beat1_data", a_wdata, 32'hD001);
        rst = 1'b1;
        #1;
        chk("mr_wren", a_wren, 0);
        chk("mr_end", a_end, 0);
        chk("mr_done", a_done, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_ready", a_ready, 1);
        qa.delete();
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'hE000 + k;
        issue(0, 2, d, s);
        run(0, 4, "post_rst");

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
